// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator.
package video_timing_pkg;

  // One video mode: horizontal values in pixels, vertical values in lines.
  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_front;
    logic [15:0] h_sync;
    logic [15:0] h_back;
    logic [15:0] v_active;
    logic [15:0] v_front;
    logic [15:0] v_sync;
    logic [15:0] v_back;
  } timing_t;

  localparam timing_t MODE_640x480_60 = '{
    h_active: 16'd640,  h_front: 16'd16,  h_sync: 16'd96, h_back: 16'd48,
    v_active: 16'd480,  v_front: 16'd10,  v_sync: 16'd2,  v_back: 16'd33
  };

  localparam timing_t MODE_1280x720_60 = '{
    h_active: 16'd1280, h_front: 16'd110, h_sync: 16'd40, h_back: 16'd220,
    v_active: 16'd720,  v_front: 16'd5,   v_sync: 16'd5,  v_back: 16'd20
  };

  // Decoded timing word carried through the output pipeline. All fields are
  // active-high here; sync polarity is applied only after the last stage.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } sync_word_t;

  localparam int SYNC_W = $bits(sync_word_t);

  // Blank state: no active video, no sync, no pulses.
  localparam sync_word_t SYNC_BLANK = '0;

endpackage

// File: rtl/video_timing_gen_sync_delay.sv
// Register chain of DEPTH stages with hold enable, synchronous flush and
// asynchronous reset, both of which load RST_VAL into every stage.
module sync_delay #(
  parameter int              WIDTH   = 5,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH < 1) begin : g_depth_check
    $error("sync_delay: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the word one stage per enabled cycle; flush wins over enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync/DE decode, a delay
// pipeline so the pixel source can have latency, and a frame counter.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int          CW         = 12,
  parameter int          PIPE_DELAY = 1,
  parameter int          FCW        = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           resync,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_LINE  = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_LINE + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  if (H_TOTAL > (64'd1 << CW)) begin : g_h_range_check
    $error("video_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (64'd1 << CW)) begin : g_v_range_check
    $error("video_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_pipe_check
    $error("video_timing_gen: PIPE_DELAY must be within 0..4");
  end

  logic [CW-1:0]  x_q, x_d;
  logic [CW-1:0]  y_q, y_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic [31:0]    x_w, y_w;
  sync_word_t     raw_w;
  sync_word_t     out_w;

  // Next raster position and frame count; resync overrides enable.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    if (resync) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fc_d = fc_q + FCW'(1);
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  end

  // Compare in 32 bits so sums equal to 2**CW cannot wrap.
  assign x_w = 32'(x_q);
  assign y_w = 32'(y_q);

  // Decode the current position. vsync edges are placed at x == HS_START so
  // they line up with the hsync leading edge.
  always_comb begin
    raw_w    = SYNC_BLANK;
    raw_w.de = (x_w < H_ACTIVE) && (y_w < V_ACTIVE);
    raw_w.hs = (x_w >= HS_START) && (x_w < HS_END);
    raw_w.vs = ((y_w == VS_LINE) && (x_w >= HS_START)) ||
               ((y_w >  VS_LINE) && (y_w < VS_END))   ||
               ((y_w == VS_END)  && (x_w < HS_START));
    raw_w.ls = (x_q == '0);
    raw_w.fs = (x_q == '0) && (y_q == '0);
  end

  // First register stage plus PIPE_DELAY further stages in one chain.
  sync_delay #(
    .WIDTH   (SYNC_W),
    .DEPTH   (1 + PIPE_DELAY),
    .RST_VAL (SYNC_BLANK)
  ) u_sync_delay (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en),
    .flush_i (resync),
    .d_i     (raw_w),
    .q_o     (out_w)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = fc_q;
  assign de          = out_w.de;
  assign line_start  = out_w.ls;
  assign frame_start = out_w.fs;
  assign hsync       = HSYNC_POL ? out_w.hs : ~out_w.hs;
  assign vsync       = VSYNC_POL ? out_w.vs : ~out_w.vs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench on a small 15x9 raster (H 8/2/3/2, V 4/1/2/2) so full frames
// are short. Instance A: PIPE_DELAY=1, hsync active-low, vsync active-high,
// 4-bit coordinates and frame counter. Instance B: PIPE_DELAY=3, hsync
// active-high, vsync active-low.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n_a, en_a, resync_a;
  logic [3:0] x_a, y_a, fc_a;
  logic       hs_a, vs_a, de_a, ls_a, fs_a;

  logic        rst_n_b, en_b, resync_b;
  logic [7:0]  x_b, y_b;
  logic [15:0] fc_b;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int n;   // enabled edges since reset release
    int x; int y; int de; int hs; int vs; int ls; int fs; int fc;
  } vec_t;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CW(4), .PIPE_DELAY(1), .FCW(4)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .resync(resync_a),
    .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(8), .PIPE_DELAY(3), .FCW(16)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .resync(resync_b),
    .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0;
    @(posedge clk);
    #1;
    rst_n_a = 1'b1;
  endtask

  task automatic reset_b();
    rst_n_b = 1'b0;
    @(posedge clk);
    #1;
    rst_n_b = 1'b1;
  endtask

  task automatic chk_a(input string tag, input vec_t v);
    chk({tag, ".x"},  int'(x_a),  v.x);
    chk({tag, ".y"},  int'(y_a),  v.y);
    chk({tag, ".de"}, int'(de_a), v.de);
    chk({tag, ".hs"}, int'(hs_a), v.hs);
    chk({tag, ".vs"}, int'(vs_a), v.vs);
    chk({tag, ".ls"}, int'(ls_a), v.ls);
    chk({tag, ".fs"}, int'(fs_a), v.fs);
    chk({tag, ".fc"}, int'(fc_a), v.fc);
  endtask

  initial begin
    vec_t vecs [19];
    int   n;
    int   cnt_de, cnt_hs_low, cnt_vs_high, cnt_ls, cnt_fs;

    rst_n_a = 1'b0; en_a = 1'b1; resync_a = 1'b0;
    rst_n_b = 1'b0; en_b = 1'b1; resync_b = 1'b0;

    // n: x y de hsync vsync ls fs fc. Outputs show the position two edges back;
    // blank is hsync=1, vsync=0 for instance A.
    vecs = '{
      '{0,   0, 0, 0, 1, 0, 0, 0, 0},
      '{1,   1, 0, 0, 1, 0, 0, 0, 0},
      '{2,   2, 0, 1, 1, 0, 1, 1, 0},
      '{3,   3, 0, 1, 1, 0, 0, 0, 0},
      '{9,   9, 0, 1, 1, 0, 0, 0, 0},
      '{10, 10, 0, 0, 1, 0, 0, 0, 0},
      '{12, 12, 0, 0, 0, 0, 0, 0, 0},
      '{14, 14, 0, 0, 0, 0, 0, 0, 0},
      '{15,  0, 1, 0, 1, 0, 0, 0, 0},
      '{17,  2, 1, 1, 1, 0, 1, 0, 0},
      '{54,  9, 3, 1, 1, 0, 0, 0, 0},
      '{62,  2, 4, 0, 1, 0, 1, 0, 0},
      '{86, 11, 5, 0, 1, 0, 0, 0, 0},
      '{87, 12, 5, 0, 0, 1, 0, 0, 0},
      '{116,11, 7, 0, 1, 1, 0, 0, 0},
      '{117,12, 7, 0, 0, 0, 0, 0, 0},
      '{134,14, 8, 0, 0, 0, 0, 0, 0},
      '{135, 0, 0, 0, 1, 0, 0, 0, 1},
      '{137, 2, 0, 1, 1, 0, 1, 1, 1}
    };

    #12;
    reset_a();
    n = 0;
    for (int i = 0; i < 19; i++) begin
      while (n < vecs[i].n) begin
        tick();
        n++;
      end
      chk_a($sformatf("vec%0d", vecs[i].n), vecs[i]);
    end

    // One full frame of steady-state output (n = 138..272).
    cnt_de = 0; cnt_hs_low = 0; cnt_vs_high = 0; cnt_ls = 0; cnt_fs = 0;
    for (int i = 0; i < 135; i++) begin
      tick();
      n++;
      cnt_de      += int'(de_a);
      cnt_hs_low  += int'(!hs_a);
      cnt_vs_high += int'(vs_a);
      cnt_ls      += int'(ls_a);
      cnt_fs      += int'(fs_a);
    end
    chk("frame.de_cycles", cnt_de, 32);
    chk("frame.hsync_low_cycles", cnt_hs_low, 27);
    chk("frame.vsync_high_cycles", cnt_vs_high, 30);
    chk("frame.line_starts", cnt_ls, 9);
    chk("frame.frame_starts", cnt_fs, 1);
    chk("frame.fc", int'(fc_a), 2);
    chk("frame.de_at_0_0", int'(de_a), 1);

    // Asynchronous reset in the middle of a frame: blank immediately.
    #2;
    rst_n_a = 1'b0;
    #1;
    chk_a("rst_mid", '{0, 0, 0, 0, 1, 0, 0, 0, 0});
    @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    n = 0;
    tick(); tick(); n = 2;
    chk_a("rst_resume", '{2, 2, 0, 1, 1, 0, 1, 1, 0});

    // Frame counter wraps at 2**FCW frames.
    while (n < 2159) begin
      tick();
      n++;
    end
    chk("wrap.fc_before", int'(fc_a), 15);
    tick();
    chk("wrap.fc_after", int'(fc_a), 0);
    chk("wrap.x", int'(x_a), 0);
    chk("wrap.y", int'(y_a), 0);

    // Enable gap of 5 cycles at x = 3: everything freezes, line's DE stretches.
    reset_a();
    cnt_de = int'(de_a);
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt_de += int'(de_a);
    end
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt_de += int'(de_a);
      chk_a($sformatf("gap%0d", i), '{3, 3, 0, 1, 1, 0, 0, 0, 0});
    end
    en_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt_de += int'(de_a);
    end
    chk("gap.de_cycles", cnt_de, 13);
    chk("gap.x_end", int'(x_a), 13);
    chk("gap.y_end", int'(y_a), 0);

    // Resync on instance B at (5,2) of its second frame. Blank for B is
    // hsync=0, vsync=1.
    reset_b();
    for (int i = 0; i < 170; i++) tick();
    chk("rs.x_before", int'(x_b), 5);
    chk("rs.y_before", int'(y_b), 2);
    chk("rs.fc_before", int'(fc_b), 1);
    chk("rs.de_before", int'(de_b), 1);
    resync_b = 1'b1;
    tick();
    resync_b = 1'b0;
    chk("rs.x", int'(x_b), 0);
    chk("rs.y", int'(y_b), 0);
    chk("rs.de", int'(de_b), 0);
    chk("rs.hsync", int'(hs_b), 0);
    chk("rs.vsync", int'(vs_b), 1);
    chk("rs.fs", int'(fs_b), 0);
    chk("rs.fc", int'(fc_b), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("rs.flush%0d.de", k), int'(de_b), 0);
      chk($sformatf("rs.flush%0d.fs", k), int'(fs_b), 0);
      chk($sformatf("rs.flush%0d.x", k), int'(x_b), k);
    end
    tick();
    chk("rs.first.de", int'(de_b), 1);
    chk("rs.first.fs", int'(fs_b), 1);
    chk("rs.first.ls", int'(ls_b), 1);
    chk("rs.first.hsync", int'(hs_b), 0);
    chk("rs.first.x", int'(x_b), 4);
    chk("rs.first.fc", int'(fc_b), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the HDMI/DVI output path. Produces pixel coordinates, hsync, vsync and data-enable for any CEA/VESA-style mode.
- Runs in the pixel clock domain. Feeds the pixel source (x/y) and the TMDS control/data mux (hsync/vsync/de).
- Compared with the current fixed 640x480 logic, it adds:
  - parametrised mode and sync polarity;
  - configurable output pipeline delay so the pixel source can have latency;
  - a count enable, a synchronous resync, frame/line pulses and a frame counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- CW, 12, coordinate width
- PIPE_DELAY, 1, extra output register stages, range 0..4
- FCW, 16, frame counter width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  count enable; when low, all state holds
- resync  in  1  synchronous restart of the frame
- x  out  CW  current horizontal counter
- y  out  CW  current vertical counter
- hsync  out  1  horizontal sync, polarity set by HSYNC_POL
- vsync  out  1  vertical sync, polarity set by VSYNC_POL
- de  out  1  data enable (active region)
- line_start  out  1  one-cycle pulse aligned with delayed x==0
- frame_start  out  1  one-cycle pulse aligned with delayed (0,0)
- frame_count  out  FCW  completed-frame counter

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters; V_TOTAL likewise; HS_START = H_ACTIVE + H_FRONT; VS_LINE = V_ACTIVE + V_FRONT.
- Elaboration error if H_TOTAL or V_TOTAL exceeds 2^CW, or PIPE_DELAY > 4.
- Reset (async, rst_n low):
  - x = 0, y = 0, frame_count = 0;
  - all pipeline stages cleared to the blank state: de = 0, hsync = !HSYNC_POL, vsync = !VSYNC_POL, line_start = 0, frame_start = 0.
- Counters, on each clk edge with en = 1 and resync = 0:
  - x increments; at x == H_TOTAL-1, x wraps to 0 and y advances;
  - y wraps to 0 at V_TOTAL-1;
  - frame_count increments (modulo 2^FCW) on the wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Decode (combinational from x, y):
  - de_raw = x < H_ACTIVE and y < V_ACTIVE;
  - hs_raw = HS_START <= x < HS_START + H_SYNC;
  - vs_raw asserts at (x = HS_START, y = VS_LINE) and deasserts at (x = HS_START, y = VS_LINE + V_SYNC), so vsync edges coincide with hsync leading edges;
  - ls_raw = x == 0; fs_raw = (x == 0 and y == 0).
- Output pipeline:
  - Decode is registered once, then passed through PIPE_DELAY further stages.
  - Outputs reflect the coordinate presented 1+PIPE_DELAY enabled cycles earlier.
  - x and y are driven straight from the counters and therefore lead the sync outputs by 1+PIPE_DELAY.
  - Polarity is applied at the final stage.
- en = 0: counters, pipeline and frame_count all hold; outputs remain static.
- resync = 1 (priority over en):
  - next edge sets x = 0, y = 0;
  - all pipeline stages are flushed to the blank state;
  - frame_count is unchanged; no frame_start is emitted for the flushed stages.
  - After that edge, normal operation resumes from (0,0) if en = 1. The first frame_start appears 1+PIPE_DELAY edges later.
- Reset mid-frame: immediate blank state; the counter restarts at (0,0) on release.

Decomposition:
- Package video_timing_pkg:
  - timing_t struct (h_active, h_front, h_sync, h_back, v_active, v_front, v_sync, v_back);
  - presets MODE_640x480_60 and MODE_1280x720_60;
  - blank-state constant for the pipeline word {de, hs, vs, ls, fs}.
- Sub-module sync_delay: a DEPTH-parametrised register chain of a WIDTH-bit word with enable, synchronous flush-to-value and async reset-to-value. Instantiated once for the 5-bit decode word.

Test Plan (defaults; H_TOTAL = 800, V_TOTAL = 525, en = 1 unless stated):
- Release reset, PIPE_DELAY = 1 -> de rises on the 2nd enabled edge, stays high for 640 cycles then low for 160; repeats for 480 lines, then 45 lines fully low.
- Horizontal sync -> hsync low for exactly 96 cycles, starting when delayed x = 656; line_start pulses every 800 cycles.
- Vertical sync -> vsync falls with the hsync falling edge at delayed (656, 490) and rises at delayed (656, 492), i.e. 1600 cycles low.
- Run 2 frames -> frame_count 0->1 after 420000 edges and 1->2 after 840000; frame_start pulses exactly 420000 cycles apart.
- Drop en for 5 cycles at x = 100 -> x, y and all outputs frozen during the gap; that line's de-high period stretches by 5 wall-clock cycles.
- Assert resync for 1 cycle at (300, 100) with PIPE_DELAY = 3 -> next edge gives x = 0, y = 0 and de = 0. de stays 0 for 4 edges, then goes high with a frame_start pulse. frame_count is unchanged.
